// File: rtl/vnu_sched.sv
// Frame scheduler and extrinsic datapath front end for the shuffled variable-node unit.
// Define VNU_EARLY_STOP_EN to let i_synd_ok end a frame at the CHECK of any iteration.
module vnu_sched #(
    parameter int unsigned W      = 11,
    parameter int unsigned DV     = 3,
    parameter int unsigned N_COL  = 64,
    parameter int unsigned N_ITER = 8,
    parameter int unsigned COL_W  = $clog2(N_COL)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    output logic                o_busy,
    output logic                o_done,
    output logic [3:0]          o_iter,
    output logic                o_rd_en,
    output logic [COL_W-1:0]    o_rd_addr,
    input  logic [W-1:0]        i_llr,
    input  logic [DV*W-1:0]     i_c2v,
    output logic                o_v2c_valid,
    input  logic                i_v2c_ready,
    output logic [COL_W-1:0]    o_v2c_addr,
    output logic [DV*W-1:0]     o_v2c,
    output logic                o_hd,
    input  logic                i_synd_ok
);

    localparam int unsigned AW = W + 2;
    localparam logic signed [AW-1:0] SAT_POS  = AW'((1 << (W - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_NEG  = -SAT_POS;
    localparam logic [COL_W-1:0]     LAST_COL = COL_W'(N_COL - 1);
    localparam logic [3:0]           LAST_ITR = 4'(N_ITER - 1);
`ifdef VNU_EARLY_STOP_EN
    localparam bit EARLY_STOP = 1'b1;
`else
    localparam bit EARLY_STOP = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [COL_W-1:0]   col;
    logic [COL_W-1:0]   col_nxt;
    logic [3:0]         iter_nxt;
    logic               adv;
    logic               rd_en;
    logic               p1;
    logic [COL_W-1:0]   p1_addr;

    logic signed [AW-1:0] total;
    logic signed [AW-1:0] ext;
    logic signed [AW-1:0] mag;
    logic [DV*W-1:0]      v2c_nxt;
    logic                 hd_nxt;

    assign o_rd_en   = rd_en;
    assign o_rd_addr = col;

    // Next-state, column/iteration counters and read issue
    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        iter_nxt  = o_iter;
        rd_en     = 1'b0;
        adv       = !o_v2c_valid || i_v2c_ready;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt = S_RUN;
                    col_nxt   = '0;
                    iter_nxt  = '0;
                end
            end
            S_RUN: begin
                if (adv) begin
                    rd_en = 1'b1;
                    if (col == LAST_COL) begin
                        state_nxt = S_DRAIN;
                    end else begin
                        col_nxt = col + COL_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (!p1 && adv) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (o_iter == LAST_ITR || (EARLY_STOP && i_synd_ok)) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_RUN;
                    iter_nxt  = o_iter + 4'd1;
                    col_nxt   = '0;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Extrinsics: total minus own lane, symmetric saturation, then sign-magnitude
    always_comb begin
        total   = AW'(signed'(i_llr));
        ext     = '0;
        mag     = '0;
        v2c_nxt = '0;
        for (int k = 0; k < DV; k++) begin
            total = total + AW'(signed'(i_c2v[k*W +: W]));
        end
        hd_nxt = total[AW-1];
        for (int k = 0; k < DV; k++) begin
            ext = total - AW'(signed'(i_c2v[k*W +: W]));
            if (ext > SAT_POS) begin
                ext = SAT_POS;
            end else if (ext < SAT_NEG) begin
                ext = SAT_NEG;
            end
            mag = ext[AW-1] ? -ext : ext;
            v2c_nxt[k*W +: W] = {ext[AW-1], (W-1)'(mag)};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            col         <= '0;
            o_iter      <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            p1          <= 1'b0;
            p1_addr     <= '0;
            o_v2c_valid <= 1'b0;
            o_v2c_addr  <= '0;
            o_v2c       <= '0;
            o_hd        <= 1'b0;
        end else begin
            state  <= state_nxt;
            col    <= col_nxt;
            o_iter <= iter_nxt;
            o_busy <= (state_nxt != S_IDLE);
            o_done <= (state_nxt == S_DONE);

            // One read may be in flight; it lands in the output register once that frees up
            if (rd_en) begin
                p1      <= 1'b1;
                p1_addr <= col;
            end else if (p1 && adv) begin
                p1 <= 1'b0;
            end

            if (p1 && adv) begin
                o_v2c_valid <= 1'b1;
                o_v2c_addr  <= p1_addr;
                o_v2c       <= v2c_nxt;
                o_hd        <= hd_nxt;
            end else if (i_v2c_ready) begin
                o_v2c_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vnu_sched.sv
// Directed bench for vnu_sched with a 4-column, 2-iteration frame and a one-cycle-latency memory model.
module tb_vnu_sched;

    localparam int unsigned W  = 11;
    localparam int unsigned DV = 3;
    localparam int unsigned NC = 4;
    localparam int unsigned NI = 2;
    localparam int unsigned CW = 2;
`ifdef VNU_EARLY_STOP_EN
    localparam int EXP_ITERS = 1;
`else
    localparam int EXP_ITERS = NI;
`endif
    localparam int EXP_XFERS = NC * EXP_ITERS;

    logic              clk = 1'b0;
    logic              i_rst = 1'b0;
    logic              i_start = 1'b0;
    logic              o_busy;
    logic              o_done;
    logic [3:0]        o_iter;
    logic              o_rd_en;
    logic [CW-1:0]     o_rd_addr;
    logic [W-1:0]      i_llr = '0;
    logic [DV*W-1:0]   i_c2v = '0;
    logic              o_v2c_valid;
    logic              i_v2c_ready = 1'b1;
    logic [CW-1:0]     o_v2c_addr;
    logic [DV*W-1:0]   o_v2c;
    logic              o_hd;
    logic              i_synd_ok = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]    llr_tab [8];
    logic [DV*W-1:0] c2v_tab [8];
    logic [DV*W-1:0] exp_v2c [8];
    logic            exp_hd  [8];

    logic m_fire;
    int   m_idx;

    vnu_sched #(.W(W), .DV(DV), .N_COL(NC), .N_ITER(NI)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_iter      (o_iter),
        .o_rd_en     (o_rd_en),
        .o_rd_addr   (o_rd_addr),
        .i_llr       (i_llr),
        .i_c2v       (i_c2v),
        .o_v2c_valid (o_v2c_valid),
        .i_v2c_ready (i_v2c_ready),
        .o_v2c_addr  (o_v2c_addr),
        .o_v2c       (o_v2c),
        .o_hd        (o_hd),
        .i_synd_ok   (i_synd_ok)
    );

    always #5 clk = ~clk;

    // Message memory: data for (iter, col) appears one cycle after the read strobe and then holds
    always @(posedge clk) begin
        m_fire = o_rd_en;
        m_idx  = int'(o_iter) * NC + int'(o_rd_addr);
        #1;
        if (m_fire && m_idx < 8) begin
            i_llr = llr_tab[m_idx];
            i_c2v = c2v_tab[m_idx];
        end
    end

    task automatic load_tables();
        llr_tab[0] = 11'(100);   c2v_tab[0] = {11'(10), 11'(-20), 11'(50)};
        exp_v2c[0] = {11'h082, 11'h0A0, 11'h05A};                 exp_hd[0] = 1'b0;
        llr_tab[1] = 11'(-100);  c2v_tab[1] = {11'(-10), 11'(20), 11'(-50)};
        exp_v2c[1] = {11'h482, 11'h4A0, 11'h45A};                 exp_hd[1] = 1'b1;
        llr_tab[2] = 11'(1023);  c2v_tab[2] = {3{11'(1023)}};
        exp_v2c[2] = {3{11'h3FF}};                                exp_hd[2] = 1'b0;
        llr_tab[3] = 11'(-1023); c2v_tab[3] = {3{11'(-1023)}};
        exp_v2c[3] = {3{11'h7FF}};                                exp_hd[3] = 1'b1;
        llr_tab[4] = 11'(10);    c2v_tab[4] = {11'(0), 11'(-20), 11'(10)};
        exp_v2c[4] = {11'h000, 11'h014, 11'h40A};                 exp_hd[4] = 1'b0;
        llr_tab[5] = 11'(-1024); c2v_tab[5] = {3{11'(-1024)}};
        exp_v2c[5] = {3{11'h7FF}};                                exp_hd[5] = 1'b1;
        llr_tab[6] = 11'(0);     c2v_tab[6] = {11'(0), 11'(-1024), 11'(1023)};
        exp_v2c[6] = {11'h401, 11'h3FF, 11'h7FF};                 exp_hd[6] = 1'b1;
        llr_tab[7] = 11'(1);     c2v_tab[7] = {3{11'(0)}};
        exp_v2c[7] = {3{11'h001}};                                exp_hd[7] = 1'b0;
    endtask

    task automatic test_reset();
        #2 i_rst = 1'b1;
        #1;
        checks++;
        if ({o_busy, o_done, o_iter, o_rd_en, o_rd_addr, o_v2c_valid, o_v2c_addr, o_v2c, o_hd} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b iter=%0d rd_en=%b rd_addr=%0d valid=%b addr=%0d v2c=%h hd=%b, required all 0",
                     o_busy, o_done, o_iter, o_rd_en, o_rd_addr, o_v2c_valid, o_v2c_addr, o_v2c, o_hd);
        end
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_rd_en !== 1'b0 || o_v2c_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b rd_en=%b valid=%b, required 0/0/0", o_busy, o_rd_en, o_v2c_valid);
        end
    endtask

    task automatic test_sequencing();
        int reads = 0;
        int xfers = 0;
        int dones = 0;
        bit done_prev = 0;
        bit finished = 0;
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        for (int c = 0; c < 100 && !finished; c++) begin
            i_start = (c == 4);
            i_v2c_ready = 1'b1;
            #1;
            if (c == 0) begin
                checks++;
                if (o_rd_en !== 1'b1 || o_rd_addr !== 2'd0 || o_busy !== 1'b1 || o_iter !== 4'd0) begin
                    errors++;
                    $display("FAIL start_latency rd_en=%b addr=%0d busy=%b iter=%0d, required 1/0/1/0",
                             o_rd_en, o_rd_addr, o_busy, o_iter);
                end
            end
            if (o_rd_en) begin
                checks++;
                if (o_rd_addr !== CW'(reads % NC) || o_iter !== 4'(reads / NC)) begin
                    errors++;
                    $display("FAIL read_order #%0d addr=%0d iter=%0d, required addr=%0d iter=%0d",
                             reads, o_rd_addr, o_iter, reads % NC, reads / NC);
                end
                reads++;
            end
            if (o_v2c_valid && i_v2c_ready) begin
                checks++;
                if (xfers >= 8 || o_v2c_addr !== CW'(xfers % NC) || o_v2c !== exp_v2c[xfers % 8] || o_hd !== exp_hd[xfers % 8]) begin
                    errors++;
                    $display("FAIL transfer #%0d addr=%0d v2c=%h hd=%b, required addr=%0d v2c=%h hd=%b",
                             xfers, o_v2c_addr, o_v2c, o_hd, xfers % NC, exp_v2c[xfers % 8], exp_hd[xfers % 8]);
                end
                xfers++;
            end
            if (done_prev) begin
                checks++;
                if (o_busy !== 1'b0 || o_done !== 1'b0) begin
                    errors++;
                    $display("FAIL after_done busy=%b done=%b, required 0/0", o_busy, o_done);
                end
                finished = 1;
            end else if (o_done) begin
                checks++;
                if (o_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL done_cycle_busy busy=%b, required 1", o_busy);
                end
                dones++;
                done_prev = 1;
            end
            @(negedge clk);
        end
        i_start = 1'b0;
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL seq_timeout finished=%b, required 1", finished);
        end
        checks++;
        if (reads != EXP_XFERS || xfers != EXP_XFERS || dones != 1) begin
            errors++;
            $display("FAIL seq_counts reads=%0d xfers=%0d dones=%0d, required %0d/%0d/1",
                     reads, xfers, dones, EXP_XFERS, EXP_XFERS);
        end
    endtask

    task automatic test_back_pressure();
        int reads = 0;
        int xfers = 0;
        int stall_left = 0;
        bit stalled = 0;
        bit finished = 0;
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        for (int c = 0; c < 200 && !finished; c++) begin
            if (!stalled && o_v2c_valid && o_v2c_addr == 2'd1) begin
                stalled = 1;
                stall_left = 5;
            end
            i_v2c_ready = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                checks++;
                if (o_v2c !== exp_v2c[1] || o_v2c_addr !== 2'd1 || o_v2c_valid !== 1'b1 || o_rd_en !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold v2c=%h addr=%0d valid=%b rd_en=%b, required %h/1/1/0",
                             o_v2c, o_v2c_addr, o_v2c_valid, o_rd_en, exp_v2c[1]);
                end
                stall_left--;
            end
            if (o_rd_en) reads++;
            if (o_v2c_valid && i_v2c_ready) begin
                checks++;
                if (xfers >= 8 || o_v2c_addr !== CW'(xfers % NC) || o_v2c !== exp_v2c[xfers % 8]) begin
                    errors++;
                    $display("FAIL bp_transfer #%0d addr=%0d v2c=%h, required addr=%0d v2c=%h",
                             xfers, o_v2c_addr, o_v2c, xfers % NC, exp_v2c[xfers % 8]);
                end
                xfers++;
            end
            if (o_done) finished = 1;
            @(negedge clk);
        end
        i_v2c_ready = 1'b1;
        checks++;
        if (!finished || !stalled || reads != EXP_XFERS || xfers != EXP_XFERS) begin
            errors++;
            $display("FAIL bp_counts finished=%b stalled=%b reads=%0d xfers=%0d, required 1/1/%0d/%0d",
                     finished, stalled, reads, xfers, EXP_XFERS, EXP_XFERS);
        end
    endtask

    task automatic test_reset_mid_run();
        bit hit = 0;
        bit finished = 0;
        int xfers = 0;
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            #1;
            if (o_rd_en && o_rd_addr == 2'd2) hit = 1;
            else @(negedge clk);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL mid_run_reach hit=%b, required 1", hit);
        end
        #2 i_rst = 1'b1;
        #1;
        checks++;
        if ({o_busy, o_done, o_iter, o_rd_en, o_rd_addr, o_v2c_valid, o_v2c_addr, o_v2c, o_hd} !== '0) begin
            errors++;
            $display("FAIL mid_run_reset busy=%b done=%b iter=%0d rd_en=%b rd_addr=%0d valid=%b addr=%0d v2c=%h hd=%b, required all 0",
                     o_busy, o_done, o_iter, o_rd_en, o_rd_addr, o_v2c_valid, o_v2c_addr, o_v2c, o_hd);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (o_done !== 1'b0 || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold done=%b busy=%b, required 0/0", o_done, o_busy);
            end
        end
        i_rst = 1'b0;
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        #1;
        checks++;
        if (o_rd_en !== 1'b1 || o_rd_addr !== 2'd0 || o_iter !== 4'd0) begin
            errors++;
            $display("FAIL restart_first_read rd_en=%b addr=%0d iter=%0d, required 1/0/0", o_rd_en, o_rd_addr, o_iter);
        end
        for (int c = 0; c < 100 && !finished; c++) begin
            if (o_v2c_valid && i_v2c_ready) begin
                checks++;
                if (xfers >= 8 || o_v2c_addr !== CW'(xfers % NC) || o_v2c !== exp_v2c[xfers % 8]) begin
                    errors++;
                    $display("FAIL restart_transfer #%0d addr=%0d v2c=%h, required addr=%0d v2c=%h",
                             xfers, o_v2c_addr, o_v2c, xfers % NC, exp_v2c[xfers % 8]);
                end
                xfers++;
            end
            if (o_done) finished = 1;
            @(negedge clk);
            #1;
        end
        checks++;
        if (!finished || xfers != EXP_XFERS) begin
            errors++;
            $display("FAIL restart_counts finished=%b xfers=%0d, required 1/%0d", finished, xfers, EXP_XFERS);
        end
    endtask

    initial begin
        load_tables();
        test_reset();
        test_sequencing();
        test_back_pressure();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vnu_sched.md
# vnu_sched

Frame-level scheduler and shared datapath front end for the shuffled variable-node unit. On a start pulse it walks all columns of the code for up to `N_ITER` iterations, reads channel LLRs and check-to-variable messages from message memory, and forms saturated extrinsic variable-to-check messages. It converts those messages from two's complement to sign-magnitude and returns them to the check-node side under a ready/valid handshake. It sits between the message memory and the VNU/CNU message network and owns iteration counting and termination.

## Interface
- `W`, 11: message width in bits (two's complement in, sign-magnitude out).
- `DV`, 3: variable-node degree; number of check messages per column.
- `N_COL`, 64: columns per frame.
- `N_ITER`, 8: maximum iterations per frame.
- `COL_W`, `$clog2(N_COL)`: column address width.

Ports:
- `i_clk`  in  1  single clock; all logic is on the rising edge.
- `i_rst`  in  1  reset; asynchronous and active-high.
- `i_start`  in  1  start-of-frame pulse; honoured only in IDLE.
- `o_busy`  out  1  high from the cycle after start is accepted through the DONE cycle.
- `o_done`  out  1  one-cycle pulse at end of frame.
- `o_iter`  out  4  current iteration index.
- `o_rd_en`  out  1  message-memory read strobe.
- `o_rd_addr`  out  COL_W  column being read.
- `i_llr`  in  W  channel LLR, two's complement; valid 1 cycle after `o_rd_en`; held by memory while `o_rd_en` is low.
- `i_c2v`  in  DV*W  check messages; lane k is at `[k*W +: W]`; same timing as `i_llr`.
- `o_v2c_valid`  out  1  extrinsic output valid.
- `i_v2c_ready`  in  1  downstream accept.
- `o_v2c_addr`  out  COL_W  column of the current output.
- `o_v2c`  out  DV*W  sign-magnitude extrinsics; lane k is `{sign, mag[W-2:0]}`.
- `o_hd`  out  1  hard decision for `o_v2c_addr`: 1 when the total is negative.
- `i_synd_ok`  in  1  syndrome-satisfied flag; only used with the early-stop feature.

## Operation
- **FSM states:** IDLE, RUN, DRAIN, CHECK, DONE.
- **IDLE:** `i_start`=1 leads to RUN with col=0 and iter=0.
- **RUN:** when `adv` is true, the block asserts `o_rd_en` with `o_rd_addr`=col and increments col. After issuing col `N_COL-1` it goes to DRAIN.
- **DRAIN:** waits until no read is in flight and the output register is empty or accepted this cycle, then goes to CHECK.
- **CHECK (one cycle):** if iter = `N_ITER-1`, or early stop is enabled and `i_synd_ok`=1, go to DONE. Otherwise increment iter, set col=0 and go to RUN.
- **DONE (one cycle):** `o_done`=1, then go to IDLE.
- **Start while not IDLE:** ignored.
- **Advance condition:** `adv = !o_v2c_valid || i_v2c_ready`.
- **In-flight flag `p1`:** set by `o_rd_en`. While `p1`=1 and `adv`, the memory data is captured into the output register; `o_v2c_valid` is set and `p1` is cleared unless a new read issues in the same cycle.
- **Stall behaviour:** while `adv`=0, no read issues and `o_v2c`, `o_v2c_addr` and `o_hd` hold stable.
- **Arithmetic, all signed at W+2 bits:**
  - total = llr + sum of all c2v[k].
  - ext[k] = total − c2v[k].
  - No intermediate overflow for any legal input.
- **Saturation:** ext[k] is clamped symmetrically to ±(2^(W-1)−1), i.e. ±1023. The value −1024 is never produced.
- **Conversion to sign-magnitude:**
  - sign = ext<0, mag = |ext|.
  - Zero is output as `{0,0}`.
  - `o_hd` = total<0, computed before saturation.

## Timing
- **Reset:** all outputs are 0, the FSM is in IDLE, and col, iter and `p1` are 0.
- **Read latency:** `o_rd_en` at cycle t gives `o_v2c_valid` at t+2 when unstalled.
- **Throughput:** one column per cycle at full rate.
- **Start:** `i_start` at t gives the first `o_rd_en` at t+1. `o_busy` rises at t+1.
- **Iteration turnaround:** DRAIN (≥1 cycle) plus CHECK (1 cycle) separate the last read of one iteration from the first read of the next.
- **Frame end:** `o_done` and `o_busy` are both high in the DONE cycle. `o_busy` is low the following cycle.
- **Handshake rules:**
  - A transfer occurs when `o_v2c_valid` and `i_v2c_ready` are both high.
  - Once asserted, `o_v2c_valid` does not drop before the transfer.
- **Reset mid-operation:** the asynchronous return to reset values is immediate. The in-flight read is discarded and no `o_done` is produced.
- **Counter wrap:** col wraps only via CHECK; iter never exceeds `N_ITER-1`.

## Configuration
- **`VNU_EARLY_STOP_EN` defined:** `i_synd_ok` is sampled in the CHECK cycle; 1 ends the frame after the current iteration.
- **`VNU_EARLY_STOP_EN` undefined:** `i_synd_ok` is ignored and every frame runs exactly `N_ITER` iterations.

## Test plan
- **Nominal arithmetic:** llr=100, c2v=(50,−20,10) → total 140; ext 90/160/130 → `o_v2c` lanes 0x05A/0x0A0/0x082; `o_hd`=0. Negative case: llr=−100, c2v=(−50,20,−10) → lanes 0x45A/0x4A0/0x482, `o_hd`=1.
- **Saturation:** llr=1023, c2v all 1023 → ext 3069 saturates to 0x3FF on every lane. All values −1023 → 0x7FF on every lane, `o_hd`=1. ext=0 → 0x000.
- **Sequencing (`N_COL`=4, `N_ITER`=2, ready=1):**
  - Reads 0,1,2,3 at iter 0, then 0,1,2,3 at iter 1.
  - Exactly 8 output transfers with matching addresses.
  - One `o_done` pulse; `o_busy` falls the next cycle.
  - `i_start` pulsed mid-frame has no effect.
- **Back-pressure:** ready is driven low for 5 cycles while col 1 is at the output → `o_v2c`/`o_v2c_addr` stay stable, at most one read stays outstanding, and the output sequence 0..3 completes with no loss or duplication.
- **Early stop:** with `VNU_EARLY_STOP_EN` and `i_synd_ok`=1 during the first CHECK, `o_done` follows after 1 iteration (4 transfers). Without the macro, the frame runs the full 8 transfers.
- **Reset mid-RUN:** `i_rst` asserted at col 2 → all outputs 0 immediately. A subsequent start runs a clean frame from col 0, iter 0.
